cs_stream_host: RTL and testbench

//  Host end of the CS sample interface. Feeds a length-N stream of 8-bit samples onto X,

---
 rtl/cs_stream_if.sv | 26 ++
 rtl/cs_stream_host.sv | 251 +++++++++++++++++++++++++
 tb/tb_cs_stream_host.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/cs_stream_if.sv
// Sample, expected-value, result and CS-facing signals between the host and its environment.
// The slave modport is the host's view; the master modport is the environment's view.
interface cs_stream_if;
  logic       smp_valid;
  logic       smp_ready;
  logic [7:0] smp_data;
  logic       exp_valid;
  logic       exp_ready;
  logic [9:0] exp_data;
  logic       res_valid;
  logic [9:0] res_data;
  logic       res_match;
  logic       cs_rst;
  logic [7:0] X;
  logic [9:0] Y;

  modport master (
    output smp_valid, smp_data, exp_valid, exp_data, Y,
    input  smp_ready, exp_ready, res_valid, res_data, res_match, cs_rst, X
  );

  modport slave (
    input  smp_valid, smp_data, exp_valid, exp_data, Y,
    output smp_ready, exp_ready, res_valid, res_data, res_match, cs_rst, X
  );
endinterface

// File: rtl/cs_stream_host.sv
// Host end of the CS sample interface: streams samples onto X, resets CS, captures Y
// and compares each windowed result against a queued expected value.
module cs_stream_host #(
  parameter int WIN       = 9,
  parameter int EXP_DEPTH = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  cs_stream_if.slave       bus,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_cnt,
  output logic             underrun,
  output logic             exp_empty_err
);

  localparam int PTR_W = $clog2(EXP_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CSRST = 2'd1,
    FEED  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] num_r;
  logic [CNT_W-1:0] smp_cnt_r;
  logic [CNT_W-1:0] smp_cnt_inc_s;
  logic             drain_cnt_r;
  logic [1:0]       tag_r;
  logic [7:0]       x_r;
  logic             cs_rst_r;
  logic             smp_ready_r;
  logic             res_valid_r;
  logic [9:0]       res_data_r;
  logic             res_match_r;
  logic             busy_r;
  logic             done_r;
  logic [CNT_W-1:0] err_cnt_r;
  logic             underrun_r;
  logic             exp_empty_err_r;

  logic             done_s;
  logic             underrun_set_s;
  logic             run_clear_s;
  logic             accept_s;
  logic             abort_s;
  logic             tag_s;
  logic             result_s;
  logic             match_s;

  logic [9:0]       exp_mem_r [EXP_DEPTH];
  logic [PTR_W:0]   wr_ptr_r;
  logic [PTR_W:0]   rd_ptr_r;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             push_s;
  logic             pop_s;
  logic [9:0]       exp_head_s;

  assign smp_cnt_inc_s = smp_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

  // Expected-value FIFO status; exp_ready reflects occupancy before any pop this cycle.
  assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
  assign fifo_full_s  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                        (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
  assign exp_head_s   = exp_mem_r[rd_ptr_r[PTR_W-1:0]];
  assign push_s       = bus.exp_valid && !fifo_full_s;

  // Next-state and per-cycle control decode.
  always_comb begin
    state_s        = state_r;
    done_s         = 1'b0;
    underrun_set_s = 1'b0;
    run_clear_s    = 1'b0;
    accept_s       = 1'b0;
    abort_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          run_clear_s = 1'b1;
          if (num_samples < CNT_W'(WIN)) begin
            state_s        = IDLE;
            done_s         = 1'b1;
            underrun_set_s = 1'b1;
          end else begin
            state_s = CSRST;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CSRST: begin
        state_s = FEED;
      end
      FEED: begin
        // CS latches X every clock, so a missing sample corrupts its window: abort.
        if (bus.smp_valid) begin
          accept_s = 1'b1;
          if (smp_cnt_inc_s == num_r) begin
            state_s = DRAIN;
          end else begin
            state_s = FEED;
          end
        end else begin
          abort_s        = 1'b1;
          underrun_set_s = 1'b1;
          done_s         = 1'b1;
          state_s        = IDLE;
        end
      end
      DRAIN: begin
        if (drain_cnt_r) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Result-side decode: a tag leaving the pipe means Y now holds that sample's window.
  always_comb begin
    tag_s    = accept_s && (smp_cnt_inc_s >= CNT_W'(WIN));
    result_s = tag_r[1] && !abort_s;
    pop_s    = result_s && !fifo_empty_s;
    if (fifo_empty_s) begin
      match_s = 1'b0;
    end else begin
      match_s = (bus.Y == exp_head_s);
    end
  end

  // Control state, sample path, tag pipe, result capture and run statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= IDLE;
      num_r           <= {CNT_W{1'b0}};
      smp_cnt_r       <= {CNT_W{1'b0}};
      drain_cnt_r     <= 1'b0;
      tag_r           <= 2'b00;
      x_r             <= 8'd0;
      cs_rst_r        <= 1'b1;
      smp_ready_r     <= 1'b0;
      res_valid_r     <= 1'b0;
      res_data_r      <= 10'd0;
      res_match_r     <= 1'b0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      err_cnt_r       <= {CNT_W{1'b0}};
      underrun_r      <= 1'b0;
      exp_empty_err_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      busy_r      <= (state_s != IDLE);
      done_r      <= done_s;
      cs_rst_r    <= (state_s == CSRST);
      smp_ready_r <= (state_s == FEED);
      drain_cnt_r <= (state_r == DRAIN);

      if (state_r == IDLE && start) begin
        num_r <= num_samples;
      end

      if (state_s == CSRST) begin
        smp_cnt_r <= {CNT_W{1'b0}};
      end else if (accept_s) begin
        smp_cnt_r <= smp_cnt_inc_s;
      end

      if (accept_s) begin
        x_r <= bus.smp_data;
      end

      if (abort_s) begin
        tag_r <= 2'b00;
      end else begin
        tag_r <= {tag_r[0], tag_s};
      end

      res_valid_r <= result_s;
      res_match_r <= result_s && match_s;
      if (result_s) begin
        res_data_r <= bus.Y;
      end

      if (run_clear_s) begin
        err_cnt_r <= {CNT_W{1'b0}};
      end else if (result_s && !match_s && (err_cnt_r != {CNT_W{1'b1}})) begin
        err_cnt_r <= err_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end

      if (underrun_set_s) begin
        underrun_r <= 1'b1;
      end else if (run_clear_s) begin
        underrun_r <= 1'b0;
      end

      if (run_clear_s) begin
        exp_empty_err_r <= 1'b0;
      end else if (result_s && fifo_empty_s) begin
        exp_empty_err_r <= 1'b1;
      end
    end
  end

  // FIFO pointers; contents survive between runs and only reset empties the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {(PTR_W+1){1'b0}};
      rd_ptr_r <= {(PTR_W+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{PTR_W{1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{PTR_W{1'b0}}, 1'b1};
      end
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (push_s) begin
      exp_mem_r[wr_ptr_r[PTR_W-1:0]] <= bus.exp_data;
    end
  end

  assign bus.smp_ready = smp_ready_r;
  assign bus.exp_ready = !fifo_full_s;
  assign bus.res_valid = res_valid_r;
  assign bus.res_data  = res_data_r;
  assign bus.res_match = res_match_r;
  assign bus.cs_rst    = cs_rst_r;
  assign bus.X         = x_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign err_cnt       = err_cnt_r;
  assign underrun      = underrun_r;
  assign exp_empty_err = exp_empty_err_r;

endmodule

// File: tb/tb_cs_stream_host.sv
// Bench for cs_stream_host with a behavioural CS (sum of last 9 X values, divided by 4).
module tb_cs_stream_host;
  localparam int WIN   = 9;
  localparam int CNT_W = 16;

  logic             clk;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] num_samples;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] err_cnt;
  logic             underrun;
  logic             exp_empty_err;

  cs_stream_if bus ();

  cs_stream_host #(.WIN(WIN), .EXP_DEPTH(16), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .num_samples  (num_samples),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .err_cnt      (err_cnt),
    .underrun     (underrun),
    .exp_empty_err(exp_empty_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CS model: latches X every edge, Y settles on the following falling edge.
  logic [7:0] cs_win [WIN];
  always @(posedge clk) begin
    if (bus.cs_rst) begin
      for (int i = 0; i < WIN; i++) cs_win[i] <= 8'd0;
    end else begin
      cs_win[0] <= bus.X;
      for (int i = 1; i < WIN; i++) cs_win[i] <= cs_win[i-1];
    end
  end
  always @(negedge clk) begin : cs_out
    int s;
    s = 0;
    for (int i = 0; i < WIN; i++) s = s + int'(cs_win[i]);
    bus.Y <= 10'(s >> 2);
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int         n;
    int         ramp;      // 0: every sample 100, 1: samples 0,1,2,...
    int         drop_at;   // 1-based sample withheld, 0 = none
    int         restart;   // re-pulse start mid-run
    int         n_exp;
    int         exp_val;
    int         exp_res;   // result count (upper bound when drop_at != 0)
    int         exp_data;  // first result value
    int         exp_match;
    int         exp_err;
    int         exp_under;
    int         exp_empty;
    int         exp_csrst;
  } vec_t;

  vec_t vecs [7];

  task automatic run(input vec_t v, input int idx);
    int nres = 0, nmatch = 0, first_data = -1, sent = 0, last_acc = -1;
    int ncsrst = 0, gap = -1;
    bit done_seen = 0, will_acc;
    string tag;
    tag = $sformatf("v%0d", idx);
    for (int i = 0; i < v.n_exp; i++) begin
      bus.exp_valid = 1'b1;
      bus.exp_data  = 10'(v.exp_val);
      step();
    end
    bus.exp_valid = 1'b0;
    num_samples = CNT_W'(v.n);
    for (int c = 0; c < 100 && !done_seen; c++) begin
      start = (c == 0) || (v.restart != 0 && c == 4);
      if (bus.smp_ready && sent < v.n && !(v.drop_at != 0 && sent + 1 == v.drop_at)) begin
        bus.smp_valid = 1'b1;
        bus.smp_data  = (v.ramp != 0) ? 8'(sent) : 8'd100;
      end else begin
        bus.smp_valid = 1'b0;
      end
      will_acc = bus.smp_ready && bus.smp_valid;
      step();
      if (will_acc) begin
        sent++;
        last_acc = c;
      end
      if (bus.cs_rst) ncsrst++;
      if (bus.res_valid) begin
        if (nres == 0) first_data = int'(bus.res_data);
        nres++;
        if (bus.res_match) nmatch++;
      end
      if (done) begin
        done_seen = 1;
        gap = c - last_acc;
      end
    end
    start = 1'b0;
    bus.smp_valid = 1'b0;
    check({tag, "_done_seen"}, int'(done_seen), 1);
    if (v.drop_at != 0) check({tag, "_nres_le"}, int'(nres <= v.exp_res), 1);
    else check({tag, "_nres"}, nres, v.exp_res);
    if (v.drop_at == 0 && v.exp_res > 0) check({tag, "_data"}, first_data, v.exp_data);
    // done shows up on the same edge as the last result: two edges after the last accept
    if (v.drop_at == 0 && v.n >= WIN) check({tag, "_done_gap"}, gap, 2);
    check({tag, "_match"}, nmatch, v.exp_match);
    check({tag, "_err_cnt"}, int'(err_cnt), v.exp_err);
    check({tag, "_underrun"}, int'(underrun), v.exp_under);
    check({tag, "_empty_err"}, int'(exp_empty_err), v.exp_empty);
    check({tag, "_csrst"}, ncsrst, v.exp_csrst);
    check({tag, "_busy"}, int'(busy), 0);
    step();
  endtask

  initial begin
    //        n  ramp drop rst nexp val  res data mat err und emp csr
    vecs[0] = '{ 9, 0,  0,  0,  1, 225,  1, 225, 1,  0,  0,  0,  1};
    vecs[1] = '{ 9, 1,  0,  0,  1,   9,  1,   9, 1,  0,  0,  0,  1};
    vecs[2] = '{ 9, 1,  0,  0,  1,  10,  1,   9, 0,  1,  0,  0,  1};
    vecs[3] = '{12, 0,  0,  0,  2, 225,  4, 225, 2,  2,  0,  1,  1};
    vecs[4] = '{20, 0, 11,  0,  0,   0,  2,   0, 0,  0,  1,  0,  1};
    vecs[5] = '{ 5, 0,  0,  0,  0,   0,  0,   0, 0,  0,  1,  0,  0};
    vecs[6] = '{10, 0,  0,  1,  2, 225,  2, 225, 2,  0,  0,  0,  1};

    reset = 1'b1;
    start = 1'b0;
    num_samples = '0;
    bus.smp_valid = 1'b0;
    bus.smp_data  = 8'd0;
    bus.exp_valid = 1'b0;
    bus.exp_data  = 10'd0;
    step();
    step();
    check("rst_X", int'(bus.X), 0);
    check("rst_cs_rst", int'(bus.cs_rst), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_err_cnt", int'(err_cnt), 0);
    check("rst_exp_ready", int'(bus.exp_ready), 1);
    check("rst_smp_ready", int'(bus.smp_ready), 0);
    check("rst_res_valid", int'(bus.res_valid), 0);
    check("rst_flags", int'({underrun, exp_empty_err, done}), 0);
    reset = 1'b0;
    step();
    check("idle_cs_rst_low", int'(bus.cs_rst), 0);

    for (int i = 0; i < 7; i++) run(vecs[i], i);

    // Reset in the middle of a run, with one expected value already queued.
    bus.exp_valid = 1'b1;
    bus.exp_data  = 10'd5;
    step();
    bus.exp_valid = 1'b0;
    num_samples = CNT_W'(12);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      bus.smp_valid = 1'b1;
      bus.smp_data  = 8'd7;
      step();
    end
    check("mid_busy_before", int'(busy), 1);
    check("mid_X_before", int'(bus.X), 7);
    reset = 1'b1;
    bus.smp_valid = 1'b0;
    step();
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_X", int'(bus.X), 0);
    check("mid_rst_cs_rst", int'(bus.cs_rst), 1);
    check("mid_rst_smp_ready", int'(bus.smp_ready), 0);
    reset = 1'b0;
    step();

    // The queued entry must be gone: 15 pushes leave room, the 16th fills the FIFO.
    for (int i = 0; i < 16; i++) begin
      bus.exp_valid = 1'b1;
      bus.exp_data  = 10'(i);
      step();
      if (i == 14) check("fifo_15_ready", int'(bus.exp_ready), 1);
    end
    bus.exp_valid = 1'b0;
    check("fifo_full_ready", int'(bus.exp_ready), 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("fifo_reset_ready", int'(bus.exp_ready), 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
